// File: rtl/kyber_hpm_result_unloader.sv
// Unloads one result polynomial from KyberHPM16PE, de-interleaves it and streams it in natural order.
// Optional macro KYBER_UNLOAD_REDUCE_EN: one conditional subtract of KQ on the read path.
module kyber_hpm_result_unloader #(
  parameter int unsigned PE_NUMBER = 16,
  parameter int unsigned READ_LAT  = 3
`ifdef KYBER_UNLOAD_REDUCE_EN
  ,
  parameter int unsigned KQ        = 3329
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    sel_b,
  output logic                    read_a,
  output logic                    read_b,
  input  logic [12*PE_NUMBER-1:0] dout_in,
  output logic [11:0]             coef_data,
  output logic                    coef_valid,
  input  logic                    coef_ready,
  output logic                    coef_last,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned CW     = 12;
  localparam int unsigned NCOEF  = 256;
  localparam int unsigned NBEAT  = NCOEF / PE_NUMBER;
  localparam int unsigned CNT_W  = 9;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(READ_LAT - 2);
  localparam logic [CNT_W-1:0] CAPT_LAST = CNT_W'(NBEAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PULSE, S_WAIT, S_CAPT, S_STRM, S_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             read_a_q, read_a_d;
  logic             read_b_q, read_b_d;
  logic [CW-1:0]    coef_data_q, coef_data_d;
  logic             coef_valid_q, coef_valid_d;
  logic             coef_last_q, coef_last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CW-1:0]    rd_raw, rd_val;
  logic             hs;

  logic [CW-1:0]    coef_mem_q [NCOEF];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_PULSE;
      S_PULSE: state_d = S_WAIT;
      S_WAIT:  if (cnt_q == WAIT_LAST) state_d = S_CAPT;
      S_CAPT:  if (cnt_q == CAPT_LAST) state_d = S_STRM;
      S_STRM:  if (coef_valid_q && coef_ready && coef_last_q) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Buffer read, optionally folded once into [0, KQ)
  always_comb begin
    rd_raw = coef_mem_q[cnt_q[7:0]];
`ifdef KYBER_UNLOAD_REDUCE_EN
    rd_val = (rd_raw >= CW'(KQ)) ? rd_raw - CW'(KQ) : rd_raw;
`else
    rd_val = rd_raw;
`endif
  end

  // Output and datapath next values; the output register refills whenever it is empty or drained
  always_comb begin
    cnt_d        = '0;
    sel_d        = sel_q;
    coef_data_d  = coef_data_q;
    coef_valid_d = 1'b0;
    coef_last_d  = 1'b0;
    hs           = coef_valid_q && coef_ready;
    unique case (state_q)
      S_IDLE: if (start) sel_d = sel_b;
      S_WAIT: if (cnt_q != WAIT_LAST) cnt_d = cnt_q + CNT_W'(1);
      S_CAPT: if (cnt_q != CAPT_LAST) cnt_d = cnt_q + CNT_W'(1);
      S_STRM: begin
        cnt_d        = cnt_q;
        coef_valid_d = coef_valid_q;
        coef_last_d  = coef_last_q;
        if (hs && coef_last_q) begin
          coef_valid_d = 1'b0;
          coef_last_d  = 1'b0;
        end else if ((!coef_valid_q || coef_ready) && !cnt_q[8]) begin
          coef_data_d  = rd_val;
          coef_last_d  = (cnt_q[7:0] == 8'hFF);
          coef_valid_d = 1'b1;
          cnt_d        = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
    read_a_d = (state_d == S_PULSE) && !sel_d;
    read_b_d = (state_d == S_PULSE) && sel_d;
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_FIN);
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      sel_q        <= 1'b0;
      read_a_q     <= 1'b0;
      read_b_q     <= 1'b0;
      coef_data_q  <= '0;
      coef_valid_q <= 1'b0;
      coef_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      read_a_q     <= read_a_d;
      read_b_q     <= read_b_d;
      coef_data_q  <= coef_data_d;
      coef_valid_q <= coef_valid_d;
      coef_last_q  <= coef_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // De-interleave: beat j lane i lands at 8j + i/2, odd lanes in the upper half
  always_ff @(posedge clk) begin
    if (state_q == S_CAPT) begin
      for (int i = 0; i < PE_NUMBER; i++) begin
        coef_mem_q[{1'(i % 2), cnt_q[3:0], 3'(i / 2)}] <= dout_in[CW*(PE_NUMBER-1-i) +: CW];
      end
    end
  end

  assign read_a     = read_a_q;
  assign read_b     = read_b_q;
  assign coef_data  = coef_data_q;
  assign coef_valid = coef_valid_q;
  assign coef_last  = coef_last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_kyber_hpm_result_unloader.sv
// Randomized bench for kyber_hpm_result_unloader against a coefficient-array model.
`timescale 1ns/1ps
module tb_kyber_hpm_result_unloader;

  localparam int unsigned NC       = 256;
  localparam int unsigned READ_LAT = 3;

  logic         clk = 1'b0;
  logic         reset, start, sel_b, coef_ready;
  logic         read_a, read_b, coef_valid, coef_last, busy, done;
  logic [191:0] dout_in;
  logic [11:0]  coef_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [11:0] src [NC];
  logic [11:0] got [NC];

  int          hs_cnt, pa_cnt, pb_cnt, pulse_cyc, done_cyc, sc;
  bit          prev_stall, prev_last_hs, done_seen, mon_en, rdy_rand, exp_sel;
  logic [11:0] prev_data;
  logic        prev_lastv;

  kyber_hpm_result_unloader dut (
    .clk(clk), .reset(reset), .start(start), .sel_b(sel_b),
    .read_a(read_a), .read_b(read_b), .dout_in(dout_in),
    .coef_data(coef_data), .coef_valid(coef_valid), .coef_ready(coef_ready),
    .coef_last(coef_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] ref_coef(input logic [11:0] v);
`ifdef KYBER_UNLOAD_REDUCE_EN
    return (v >= 12'd3329) ? v - 12'd3329 : v;
`else
    return v;
`endif
  endfunction

  // Multiplier model: after a read pulse, beats follow READ_LAT cycles later, garbage otherwise
  always begin
    @(negedge clk);
    if (read_a || read_b) begin
      repeat (READ_LAT) @(negedge clk);
      for (int j = 0; j < 16; j++) begin
        for (int i = 0; i < 16; i++)
          dout_in[12*(15-i) +: 12] = src[8*j + i/2 + (i%2)*128];
        @(negedge clk);
      end
      dout_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    end
  end

  always @(posedge clk) begin
    #1;
    coef_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Per-cycle compare against the expected stream
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        chk("stall_valid", 32'(coef_valid), 32'd1);
        chk("stall_data", 32'(coef_data), 32'(prev_data));
        chk("stall_last", 32'(coef_last), 32'(prev_lastv));
      end
      chk("done", 32'(done), 32'(prev_last_hs));
      if (done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
      if (coef_valid) begin
        chk("busy_valid", 32'(busy), 32'd1);
        if (hs_cnt >= NC) begin
          checks++;
          errors++;
          $display("FAIL extra_beat actual=%0d beats required=%0d", hs_cnt + 1, NC);
        end else begin
          chk("data", 32'(coef_data), 32'(ref_coef(src[hs_cnt])));
          chk("last", 32'(coef_last), 32'(hs_cnt == NC - 1));
        end
      end
      if (read_a || read_b) begin
        chk("pulse_sel", 32'(read_b), 32'(exp_sel));
        chk("pulse_both", 32'(read_a & read_b), 32'd0);
        if (read_a) pa_cnt++;
        if (read_b) pb_cnt++;
        pulse_cyc = cyc;
      end
      prev_stall   = coef_valid && !coef_ready;
      prev_data    = coef_data;
      prev_lastv   = coef_last;
      prev_last_hs = coef_valid && coef_ready && (hs_cnt == NC - 1);
      if (coef_valid && coef_ready) begin
        if (hs_cnt < NC) got[hs_cnt] = coef_data;
        hs_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_clear();
    hs_cnt = 0; pa_cnt = 0; pb_cnt = 0;
    prev_stall = 1'b0; prev_last_hs = 1'b0; done_seen = 1'b0;
    pulse_cyc = -1; done_cyc = -1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_read_a"}, 32'(read_a), 32'd0);
    chk({tag, "_read_b"}, 32'(read_b), 32'd0);
    chk({tag, "_valid"}, 32'(coef_valid), 32'd0);
    chk({tag, "_last"}, 32'(coef_last), 32'd0);
    chk({tag, "_data"}, 32'(coef_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // One unload: start, optional ignored re-starts, bounded wait for done, then totals
  task automatic run(input bit sb, input bit extra, input bit timed, output int start_cyc);
    mon_clear();
    exp_sel = sb;
    tick();
    start = 1'b1; sel_b = sb; start_cyc = cyc;
    for (int n = 0; n < 4000 && !done_seen; n++) begin
      tick();
      if (extra && (n == 4 || n == 40)) begin
        start = 1'b1; sel_b = ~sb;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("done_seen", 32'(done_seen), 32'd1);
    chk("hs_total", 32'(hs_cnt), 32'(NC));
    chk("pulse_a_cnt", 32'(pa_cnt), 32'(!sb));
    chk("pulse_b_cnt", 32'(pb_cnt), 32'(sb));
    chk("pulse_cycle", 32'(pulse_cyc), 32'(start_cyc + 1));
    if (timed) chk("done_latency", 32'(done_cyc - pulse_cyc), 32'(READ_LAT + 16 + 256 + 1));
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sel_b = 1'b0; dout_in = '0;
    rdy_rand = 1'b0; mon_en = 1'b0; exp_sel = 1'b0;
    mon_clear();
    repeat (3) tick();
    check_zero("reset");
    reset = 1'b0;
    mon_en = 1'b1;

    // Identity data, read_a, continuous ready
    for (int k = 0; k < NC; k++) src[k] = 12'(k);
    run(1'b0, 1'b0, 1'b1, sc);
    chk("lit_got0", 32'(got[0]), 32'd0);
    chk("lit_got129", 32'(got[129]), 32'd129);
    chk("lit_got255", 32'(got[255]), 32'd255);

    // Random data via read_b
    for (int k = 0; k < NC; k++) src[k] = 12'($urandom);
    run(1'b1, 1'b0, 1'b1, sc);

    // Random backpressure
    rdy_rand = 1'b1;
    for (int k = 0; k < NC; k++) src[k] = 12'($urandom);
    run(1'b0, 1'b0, 1'b0, sc);
    rdy_rand = 1'b0;

    // Start re-asserted during capture and streaming
    for (int k = 0; k < NC; k++) src[k] = 12'($urandom);
    run(1'b0, 1'b1, 1'b1, sc);

    // Reset at stream index 100, with start held alongside reset
    mon_clear();
    exp_sel = 1'b0;
    tick();
    start = 1'b1; sel_b = 1'b0;
    tick();
    start = 1'b0;
    for (int n = 0; n < 2000 && hs_cnt < 100; n++) tick();
    chk("reach_idx100", 32'(hs_cnt >= 100), 32'd1);
    mon_en = 1'b0;
    reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    check_zero("midreset");
    tick();
    chk("no_pulse_after_reset", 32'(read_a | read_b | busy), 32'd0);
    mon_clear();
    mon_en = 1'b1;
    for (int k = 0; k < NC; k++) src[k] = 12'($urandom);
    run(1'b0, 1'b0, 1'b1, sc);

    // Values around the modulus
    for (int k = 0; k < NC; k++) src[k] = 12'(k);
    src[0] = 12'hD01; src[1] = 12'hD02; src[2] = 12'hD00; src[3] = 12'hFFF;
    run(1'b1, 1'b0, 1'b1, sc);
`ifdef KYBER_UNLOAD_REDUCE_EN
    chk("lit_red_d01", 32'(got[0]), 32'h000);
    chk("lit_red_d02", 32'(got[1]), 32'h001);
    chk("lit_red_d00", 32'(got[2]), 32'hD00);
    chk("lit_red_fff", 32'(got[3]), 32'h2FE);
`else
    chk("lit_raw_d01", 32'(got[0]), 32'hD01);
    chk("lit_raw_d02", 32'(got[1]), 32'hD02);
    chk("lit_raw_d00", 32'(got[2]), 32'hD00);
    chk("lit_raw_fff", 32'(got[3]), 32'hFFF);
`endif

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
